btn_event_classifier: RTL and testbench

- Downstream of the debouncer; consumes the clean debounced level `db` and classifies it into discrete button events: press/release edges, short press, long press and double click.
- Produces single-cycle event pulses plus a wrapping press counter for the display/control logic.
- Pure synchronous block: one clock domain, no handshake with consumers; pulses are fire-and-forget.

---
 rtl/btn_pkg.sv | 31 +++
 rtl/tick_gen.sv | 36 +++
 rtl/btn_event_classifier.sv | 150 +++++++++++++++
 tb/tb_btn_event_classifier.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
//------------------------------------------------------------------------------
// Module   : btn_pkg
// Brief    : Shared FSM state type and default gesture timing for the button
//            event classifier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package btn_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    WAIT2    = 3'd3,
    PRESSED2 = 3'd4
  } state_t;

  localparam int c_long_t   = 800;
  localparam int c_dbl_t    = 250;
  localparam int c_repeat_t = 200;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
//------------------------------------------------------------------------------
// Module   : tick_gen
// Brief    : Free-running prescaler producing a one-cycle tick every TICK_DIV
//            clocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              c_cw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/btn_event_classifier.sv
//------------------------------------------------------------------------------
// Module   : btn_event_classifier
// Brief    : Classifies a debounced button level into press/release, short,
//            long and double-click pulses plus a wrapping press counter.
//            Optional auto-repeat while held: define BTN_REPEAT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_event_classifier
  import btn_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int LONG_T   = c_long_t,
  parameter int DBL_T    = c_dbl_t,
  parameter int REPEAT_T = c_repeat_t,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             db,
  output logic             press_tick,
  output logic             release_tick,
  output logic             short_press,
  output logic             long_press,
  output logic             double_click,
  output logic             repeat_tick,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int              c_tw        = $clog2(max3(LONG_T, DBL_T, REPEAT_T)) + 1;
  localparam logic [c_tw-1:0] c_tmax      = '1;
  localparam logic [c_tw-1:0] c_long_last = c_tw'(LONG_T - 1);
  localparam logic [c_tw-1:0] c_dbl_last  = c_tw'(DBL_T - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [c_tw-1:0] c_rep_last  = c_tw'(REPEAT_T - 1);
  logic r_repeat;
`endif

  state_t          r_state;
  logic [c_tw-1:0] r_timer;
  logic            r_db_d;
  logic            w_tick;
  logic            w_rise;
  logic            w_fall;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // db_d resets low, so a button already held at reset release is a press
  assign w_rise = db & ~r_db_d;
  assign w_fall = ~db & r_db_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_db_d       <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      press_cnt    <= '0;
`ifdef BTN_REPEAT_EN
      r_repeat     <= 1'b0;
`endif
    end else begin
      r_db_d       <= db;
      press_tick   <= w_rise;
      release_tick <= w_fall;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_repeat     <= 1'b0;
`endif
      if (w_rise) begin
        press_cnt <= press_cnt + 1'b1;
      end
      // Saturating tick count; every transition below overrides it with 0
      if (w_tick && (r_timer != c_tmax)) begin
        r_timer <= r_timer + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PRESSED;
            r_timer <= '0;
          end
        end
        PRESSED: begin
          if (w_fall) begin
            r_state <= WAIT2;
            r_timer <= '0;
          end else if (w_tick && (r_timer == c_long_last)) begin
            long_press <= 1'b1;
            r_state    <= HELD;
            r_timer    <= '0;
          end
        end
        HELD: begin
          if (w_fall) begin
            r_state <= IDLE;
            r_timer <= '0;
`ifdef BTN_REPEAT_EN
          end else if (w_tick && (r_timer == c_rep_last)) begin
            r_repeat <= 1'b1;
            r_timer  <= '0;
`endif
          end
        end
        WAIT2: begin
          if (w_rise) begin
            double_click <= 1'b1;
            r_state      <= PRESSED2;
            r_timer      <= '0;
          end else if (w_tick && (r_timer == c_dbl_last)) begin
            short_press <= 1'b1;
            r_state     <= IDLE;
            r_timer     <= '0;
          end
        end
        PRESSED2: begin
          if (w_fall) begin
            r_state <= IDLE;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  assign repeat_tick = r_repeat;
`else
  assign repeat_tick = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_event_classifier.sv
//------------------------------------------------------------------------------
// Module   : tb_btn_event_classifier
// Brief    : Self-checking bench for btn_event_classifier (gesture-level model
//            plus directed pulse-count and timing checks).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_btn_event_classifier;

  localparam int TD = 4;
  localparam int LT = 10;
  localparam int DT = 5;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       db = 1'b0;
  logic       press_tick, release_tick, short_press, long_press;
  logic       double_click, repeat_tick;
  logic [7:0] press_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  btn_event_classifier #(
    .TICK_DIV (TD),
    .LONG_T   (LT),
    .DBL_T    (DT),
    .REPEAT_T (RT),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db           (db),
    .press_tick   (press_tick),
    .release_tick (release_tick),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .repeat_tick  (repeat_tick),
    .press_cnt    (press_cnt)
  );

  always #5 clk = ~clk;

  // Gesture model: edge index e counts clock edges since reset release;
  // ticks fall on edges where (e+1) is a multiple of TD.
  int         edge_idx = 0;
  bit         m_prev = 0, m_active = 0, m_down = 0, m_second = 0, m_long = 0;
  int         m_entry = 0;
  logic [7:0] m_cnt = '0;
  int         c_press = 0, c_rel = 0, c_short = 0, c_long = 0, c_dbl = 0, c_rep = 0;
  int         last_short_e = -1, last_long_e = -1, last_rep_e = -1;

  always @(posedge clk) begin
    bit rise, fall, tk, es, el, ed, er;
    int e, n;
    logic [13:0] exp_v, act_v;
    if (!reset) begin
      m_prev = 0; m_active = 0; m_down = 0; m_second = 0; m_long = 0;
      m_cnt = '0; edge_idx = 0;
      #1;
      act_v = {press_tick, release_tick, short_press, long_press, double_click,
               repeat_tick, press_cnt};
      n_cmp++;
      if (act_v != 14'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %b expected all zero", act_v);
      end
    end else begin
      e    = edge_idx;
      rise = db && !m_prev;
      fall = !db && m_prev;
      tk   = ((e + 1) % TD) == 0;
      n    = (e + 1) / TD - (m_entry + 1) / TD;
      es = 0; el = 0; ed = 0; er = 0;
      if (rise) m_cnt = m_cnt + 8'd1;
      if (!m_active) begin
        if (rise) begin
          m_active = 1; m_down = 1; m_second = 0; m_long = 0; m_entry = e;
        end
      end else if (m_down && m_long) begin
        if (fall) m_active = 0;
`ifdef BTN_REPEAT_EN
        else if (tk && n == RT) begin er = 1; m_entry = e; end
`endif
      end else if (m_down && !m_second) begin
        if (fall) begin m_down = 0; m_entry = e; end
        else if (tk && n == LT) begin el = 1; m_long = 1; m_entry = e; end
      end else if (m_down) begin
        if (fall) m_active = 0;
      end else begin
        if (rise) begin ed = 1; m_down = 1; m_second = 1; m_entry = e; end
        else if (tk && n == DT) begin es = 1; m_active = 0; end
      end
      m_prev = db;
      edge_idx++;
      exp_v = {rise, fall, es, el, ed, er, m_cnt};
      #1;
      act_v = {press_tick, release_tick, short_press, long_press, double_click,
               repeat_tick, press_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL edge%0d outputs: got %b expected %b", e, act_v, exp_v);
      end
      if (press_tick)   c_press++;
      if (release_tick) c_rel++;
      if (short_press)  begin c_short++; last_short_e = e; end
      if (long_press)   begin c_long++;  last_long_e  = e; end
      if (double_click) c_dbl++;
      if (repeat_tick)  begin c_rep++;   last_rep_e   = e; end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the index of the next edge, chosen so that it is itself a tick edge
  task automatic align(output int p);
    for (int i = 0; i < TD; i++) begin
      if ((edge_idx + 1) % TD == 0) break;
      @(negedge clk);
    end
    p = edge_idx;
  endtask

  int p, s_press, s_rel, s_short, s_long, s_dbl, s_rep, s_cnt;

  task automatic snap();
    s_press = c_press; s_rel = c_rel; s_short = c_short; s_long = c_long;
    s_dbl = c_dbl; s_rep = c_rep; s_cnt = int'(press_cnt);
  endtask

  initial begin
    hold(3);
    reset = 1'b1;
    hold(5);

    // Short press: fall on a tick edge, short fires on the 5th tick after (20 edges)
    snap(); align(p); db = 1'b1; hold(20); db = 1'b0; hold(40);
    chk("short_press_tick",   c_press - s_press, 1);
    chk("short_release_tick", c_rel - s_rel, 1);
    chk("short_count",        c_short - s_short, 1);
    chk("short_no_long",      c_long - s_long, 0);
    chk("short_offset",       last_short_e - p, 40);
    chk("short_press_cnt",    int'(press_cnt), 1);

    // Long press: 10th tick after press lands 40 edges later
    snap(); align(p); db = 1'b1;
`ifdef BTN_REPEAT_EN
    hold(100);
`else
    hold(60);
`endif
    db = 1'b0; hold(40);
    chk("long_count",    c_long - s_long, 1);
    chk("long_offset",   last_long_e - p, 40);
    chk("long_no_short", c_short - s_short, 0);
`ifdef BTN_REPEAT_EN
    // repeats at +52,+64,+76,+88; the one at +100 collides with the fall
    chk("repeat_count",  c_rep - s_rep, 4);
    chk("repeat_last",   last_rep_e - p, 88);
`else
    chk("repeat_off",    c_rep - s_rep, 0);
`endif

    // Double click
    snap(); db = 1'b1; hold(8); db = 1'b0; hold(8); db = 1'b1; hold(8); db = 1'b0; hold(40);
    chk("dbl_count",    c_dbl - s_dbl, 1);
    chk("dbl_no_short", c_short - s_short, 0);
    chk("dbl_cnt_inc",  int'(press_cnt) - s_cnt, 2);

    // Fall coincides with the LONG_T expiry tick: fall wins
    snap(); align(p); db = 1'b1; hold(40); db = 1'b0; hold(40);
    chk("coinc_no_long",  c_long - s_long, 0);
    chk("coinc_short",    c_short - s_short, 1);
    chk("coinc_short_at", last_short_e - p, 60);

    // Triple click: one double_click, third press becomes a short press
    snap();
    db = 1'b1; hold(8); db = 1'b0; hold(8); db = 1'b1; hold(8);
    db = 1'b0; hold(8); db = 1'b1; hold(8); db = 1'b0; hold(40);
    chk("triple_dbl",   c_dbl - s_dbl, 1);
    chk("triple_short", c_short - s_short, 1);

    // Reset while waiting for a second press discards the gesture
    db = 1'b1; hold(8); db = 1'b0; hold(4);
    snap(); reset = 1'b0; hold(3); reset = 1'b1; hold(40);
    chk("rst_no_events", (c_press - s_press) + (c_rel - s_rel) + (c_short - s_short)
                         + (c_long - s_long) + (c_dbl - s_dbl), 0);
    chk("rst_press_cnt", int'(press_cnt), 0);

    // Reset released with the button already down counts as a press
    reset = 1'b0; db = 1'b1; hold(2);
    snap(); reset = 1'b1; hold(4);
    chk("rst_high_press", c_press - s_press, 1);
    chk("rst_high_cnt",   int'(press_cnt), 1);
    db = 1'b0; hold(40);
    chk("rst_high_short", c_short - s_short, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
